// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter slice.
package hir_arb_pkg;

   localparam int DATA_W_DEF = 32;

   // Tag index field is sized for the largest supported requester count (16).
   localparam int IDX_W = 4;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts at the internal pointer
// and wraps. Grants are suppressed while rst_n is low.
module rr_arbiter
   import hir_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = clog2_min1(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   localparam int unsigned N_U = NUM_REQ;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             found;

   // Priority search from ptr with wrap, grant decode and pointer advance.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      found     = 1'b0;
      grant     = '0;
      grant_idx = '0;
      for (int unsigned i = 0; i < N_U; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= N_U) cand = cand - N_U;
         if (!found && req[cand[PTR_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
      if (!rst_n) found = 1'b0;
      if (found) grant[grant_idx] = 1'b1;
      ptr_d = ptr_q;
      if (found) ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters with round-robin
// issue and a tag pipe that routes each product back to its owner.
// Optional statistics counters: define MULT_SHARE_ARB_STATS_EN.
module mult_share_arbiter
   import hir_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MULT_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_in1,
   input  logic [NUM_REQ*DATA_W-1:0] req_in2,
   output logic [NUM_REQ-1:0]        req_grant,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic [DATA_W-1:0]         mult_in1,
   output logic [DATA_W-1:0]         mult_in2,
   output logic                      mult_tstart,
   input  logic [DATA_W-1:0]         mult_out
`ifdef MULT_SHARE_ARB_STATS_EN
   ,
   output logic [31:0]               stat_issue_cnt,
   output logic [31:0]               stat_stall_cnt
`endif
);

   localparam int PTR_W = clog2_min1(NUM_REQ);

   logic [PTR_W-1:0]              grant_idx;
   tag_t [MULT_LATENCY-1:0]       tag_q, tag_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .grant     (req_grant),
      .grant_idx (grant_idx)
   );

   // Operand mux from the granted slice; zero when idle.
   always_comb begin
      mult_in1    = '0;
      mult_in2    = '0;
      mult_tstart = |req_grant;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_grant[i]) begin
            mult_in1 = req_in1[i*DATA_W +: DATA_W];
            mult_in2 = req_in2[i*DATA_W +: DATA_W];
         end
      end
   end

   // Tag pipe next state: load owner at entry 0, shift the rest.
   always_comb begin
      tag_d          = tag_q;
      tag_d[0].valid = |req_grant;
      tag_d[0].idx   = IDX_W'(grant_idx);
      for (int unsigned i = 1; i < MULT_LATENCY; i++) tag_d[i] = tag_q[i-1];
   end

   // Tag pipe register; reset discards in-flight ownership.
   always_ff @(posedge clk) begin
      if (!rst_n) tag_q <= '0;
      else        tag_q <= tag_d;
   end

   // Response routing from the oldest tag; gated during reset.
   always_comb begin
      resp_valid = '0;
      resp_data  = '0;
      if (rst_n && tag_q[MULT_LATENCY-1].valid) begin
         resp_valid[tag_q[MULT_LATENCY-1].idx[PTR_W-1:0]] = 1'b1;
         resp_data = mult_out;
      end
   end

`ifdef MULT_SHARE_ARB_STATS_EN
   logic [31:0] stat_issue_q, stat_issue_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Saturating issue and stall counters.
   always_comb begin
      stat_issue_d = stat_issue_q;
      stat_stall_d = stat_stall_q;
      if (mult_tstart && stat_issue_q != '1) stat_issue_d = stat_issue_q + 1'b1;
      if (|(req_valid & ~req_grant) && stat_stall_q != '1) stat_stall_d = stat_stall_q + 1'b1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_issue_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_issue_q <= stat_issue_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_issue_cnt = stat_issue_q;
   assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with a queue-based reference model
// and a behavioural two-stage multiplier.
module tb_mult_share_arbiter;

   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_in1, req_in2;
   logic [N-1:0]   req_grant, resp_valid;
   logic [W-1:0]   resp_data, mult_in1, mult_in2, mult_out;
   logic           mult_tstart;
`ifdef MULT_SHARE_ARB_STATS_EN
   logic [31:0]    stat_issue_cnt, stat_stall_cnt;
`endif

   always #5 clk = ~clk;

   mult_share_arbiter #(
      .NUM_REQ      (N),
      .DATA_W       (W),
      .MULT_LATENCY (L)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_in1     (req_in1),
      .req_in2     (req_in2),
      .req_grant   (req_grant),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .mult_in1    (mult_in1),
      .mult_in2    (mult_in2),
      .mult_tstart (mult_tstart),
      .mult_out    (mult_out)
`ifdef MULT_SHARE_ARB_STATS_EN
      ,
      .stat_issue_cnt (stat_issue_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   // Behavioural shared multiplier: two register stages, 32-bit truncation.
   logic [W-1:0] mult_s1, mult_s2;
   always @(posedge clk) begin
      mult_s1 <= mult_in1 * mult_in2;
      mult_s2 <= mult_s1;
   end
   assign mult_out = mult_s2;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model state.
   typedef struct {
      int          due;
      int          owner;
      logic [31:0] prod;
   } pend_t;
   pend_t       pend_q[$];
   int          ptr = 0;
   int          cyc = 0;
   longint      exp_issue = 0;
   longint      exp_stall = 0;

   task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
      req_in1[r*W +: W] = a;
      req_in2[r*W +: W] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
   endtask

   // One cycle: drive, check at negedge, advance model, move past posedge.
   task automatic step(input logic rst_in, input logic [N-1:0] v);
      int           g;
      logic [N-1:0] eg;
      logic [N-1:0] ev;
      logic [31:0]  ed, ea, eb;
      pend_t        p;
      rst_n     = rst_in;
      req_valid = v;
      @(negedge clk);
`ifdef MULT_SHARE_ARB_STATS_EN
      check_eq("stat_issue", stat_issue_cnt, exp_issue);
      check_eq("stat_stall", stat_stall_cnt, exp_stall);
`endif
      g = -1;
      if (rst_in) begin
         for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) begin
               g = (ptr + k) % N;
               break;
            end
         end
      end
      eg = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
         eg[g] = 1'b1;
         ea    = req_in1[g*W +: W];
         eb    = req_in2[g*W +: W];
      end
      check_eq("req_grant", req_grant, eg);
      check_eq("mult_tstart", mult_tstart, (g >= 0));
      check_eq("mult_in1", mult_in1, ea);
      check_eq("mult_in2", mult_in2, eb);

      ev = '0;
      ed = '0;
      if (rst_in && pend_q.size() > 0 && pend_q[0].due == cyc) begin
         p = pend_q.pop_front();
         ev[p.owner] = 1'b1;
         ed = p.prod;
      end
      check_eq("resp_valid", resp_valid, ev);
      check_eq("resp_data", resp_data, ed);

      if (!rst_in) begin
         pend_q.delete();
         ptr       = 0;
         exp_issue = 0;
         exp_stall = 0;
      end else begin
         if (g >= 0) begin
            p.due   = cyc + L;
            p.owner = g;
            p.prod  = ea * eb;
            pend_q.push_back(p);
            ptr = (g + 1) % N;
            exp_issue++;
         end
         if ((v & ~eg) != '0) exp_stall++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_in1   = '0;
      req_in2   = '0;
      #1;

      // Reset with requests present: no grants, no responses.
      rand_ops();
      step(1'b0, 4'b1111);
      step(1'b0, 4'b0101);

      // Single requester, 7*6.
      set_op(1, 32'd7, 32'd6);
      step(1'b1, 4'b0010);
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);

      // All four from reset, continuous.
      step(1'b0, 4'b0000);
      for (int c = 0; c < 9; c++) begin
         rand_ops();
         step(1'b1, 4'b1111);
      end
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);

      // Pointer wrap: grant to 2, then 0, then pointer at 1.
      step(1'b0, 4'b0000);
      rand_ops();
      step(1'b1, 4'b0100);
      step(1'b1, 4'b0001);
      step(1'b1, 4'b0011);

      // Wrap arithmetic on requester 3.
      set_op(3, 32'hFFFF_FFFF, 32'd2);
      step(1'b1, 4'b1000);
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);

      // Reset mid-flight, then pointer back at 0.
      rand_ops();
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      step(1'b0, 4'b1111);
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);
      step(1'b1, 4'b1111);

      // Three requesters for six cycles.
      step(1'b0, 4'b0000);
      for (int c = 0; c < 6; c++) begin
         rand_ops();
         step(1'b1, 4'b0111);
      end
      step(1'b1, 4'b0000);

      // Random traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         rand_ops();
         step(($urandom_range(0, 49) != 0), 4'($urandom));
      end
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);

      check_eq("pending_drained", pend_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
